// File: rtl/mpx_pkg.sv
// Shared MPX stereo definitions: demux state encoding, APB register offsets,
// CTRL/STATUS bit positions and the pilot-removal helper used by encoder and decoder.
package mpx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT_R = 2'd1,
      ST_WAIT_L = 2'd2
   } demux_state_t;

   localparam logic [3:0] REG_CTRL     = 4'h0;
   localparam logic [3:0] REG_TIMEOUT  = 4'h4;
   localparam logic [3:0] REG_PAIR_CNT = 4'h8;
   localparam logic [3:0] REG_STATUS   = 4'hC;

   localparam int CTRL_ENABLE    = 0;
   localparam int CTRL_SWAP      = 1;
   localparam int CTRL_RESYNC    = 2;
   localparam int CTRL_CLR_STATS = 3;

   localparam int STATUS_LOCKED    = 0;
   localparam int STATUS_STATE_LSB = 1;
   localparam int STATUS_TCNT_LSB  = 8;

   localparam logic [7:0] TCNT_MAX = 8'hFF;

   // Encoder adds pilot*256 to the sample; subtracting it modulo 2^16 is the exact inverse.
   function automatic logic [15:0] remove_pilot(input logic [15:0]        mpx,
                                                input logic signed [15:0] pilot);
      logic [15:0] scaled;
      scaled = pilot << 8;
      return mpx - scaled;
   endfunction

   function automatic logic [31:0] pack_status(input logic         locked,
                                               input demux_state_t st,
                                               input logic [7:0]   tcnt);
      logic [31:0] word;
      word                            = '0;
      word[STATUS_LOCKED]             = locked;
      word[STATUS_STATE_LSB +: 2]     = st;
      word[STATUS_TCNT_LSB +: 8]      = tcnt;
      return word;
   endfunction

endpackage

// File: rtl/stereo_demux_if.sv
// Zero-wait APB slave bus for the stereo demux register block.
// No pready: every access completes in its access phase, prdata is combinational.
interface stereo_demux_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata
   );
endinterface

// File: rtl/demux_regs.sv
// APB register file for stereo_demux: CTRL/TIMEOUT storage plus PAIR_COUNT/STATUS readback.
// Writes land on the access-phase edge; resync/clr_stats are same-cycle pulses and read back 0.
module demux_regs
   import mpx_pkg::*;
#(
   parameter logic [31:0] TIMEOUT_DEFAULT = 32'd1024
) (
   input  logic         clk,
   input  logic         reset,
   stereo_demux_if.slave apb,
   input  logic         locked_i,
   input  demux_state_t state_i,
   input  logic [7:0]   timeout_cnt_i,
   input  logic [31:0]  pair_count_i,
   output logic         enable_o,
   output logic         swap_o,
   output logic         resync_o,
   output logic         clr_stats_o,
   output logic [31:0]  timeout_o
);

   logic        wr_en;
   logic        enable_q, enable_d;
   logic        swap_q, swap_d;
   logic [31:0] timeout_q, timeout_d;
   logic        unused_addr;

   assign wr_en       = apb.psel & apb.penable & apb.pwrite;
   assign unused_addr = ^apb.paddr[31:4];

   always_comb begin
      enable_d    = enable_q;
      swap_d      = swap_q;
      timeout_d   = timeout_q;
      resync_o    = 1'b0;
      clr_stats_o = 1'b0;
      if (wr_en) begin
         case (apb.paddr[3:0])
            REG_CTRL: begin
               enable_d    = apb.pwdata[CTRL_ENABLE];
               swap_d      = apb.pwdata[CTRL_SWAP];
               resync_o    = apb.pwdata[CTRL_RESYNC];
               clr_stats_o = apb.pwdata[CTRL_CLR_STATS];
            end
            REG_TIMEOUT: timeout_d = apb.pwdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable_q  <= 1'b0;
         swap_q    <= 1'b0;
         timeout_q <= TIMEOUT_DEFAULT;
      end else begin
         enable_q  <= enable_d;
         swap_q    <= swap_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      apb.prdata = '0;
      case (apb.paddr[3:0])
         REG_CTRL: begin
            apb.prdata[CTRL_ENABLE] = enable_q;
            apb.prdata[CTRL_SWAP]   = swap_q;
         end
         REG_TIMEOUT:  apb.prdata = timeout_q;
         REG_PAIR_CNT: apb.prdata = pair_count_i;
         REG_STATUS:   apb.prdata = pack_status(locked_i, state_i, timeout_cnt_i);
         default: ;
      endcase
   end

   assign enable_o  = enable_q;
   assign swap_o    = swap_q;
   assign timeout_o = timeout_q;

endmodule

// File: rtl/stereo_demux.sv
// Stereo MPX demux: strips pilot*256 from each strobed sample and pairs first(R)/second(L).
// out_valid pulses 1 clk after the L strobe; no backpressure, samples outside WAIT_R/WAIT_L are dropped.
module stereo_demux
   import mpx_pkg::*;
#(
   parameter logic [31:0] TIMEOUT_DEFAULT = 32'd1024
) (
   input  logic               clk,
   input  logic               reset,
   stereo_demux_if.slave      apb,
   input  logic [15:0]        mpx_in,
   input  logic               mpx_valid,
   input  logic signed [15:0] pilot_ref,
   output logic [15:0]        out_l,
   output logic [15:0]        out_r,
   output logic               out_valid
);

   demux_state_t state_q, state_d;
   logic [15:0]  clean;
   logic [15:0]  first_q, first_d;
   logic [31:0]  gap_q, gap_d, gap_next;
   logic         gap_hit;
   logic         locked_q, locked_d;
   logic [7:0]   tcnt_q, tcnt_d;
   logic [31:0]  pair_cnt_q, pair_cnt_d;
   logic [15:0]  out_l_q, out_l_d;
   logic [15:0]  out_r_q, out_r_d;
   logic         out_vld_q, out_vld_d;
   logic         take_first, pair_done, timeout_evt;
   logic         enable, swap, resync, clr_stats;
   logic [31:0]  timeout;

   demux_regs #(
      .TIMEOUT_DEFAULT (TIMEOUT_DEFAULT)
   ) u_regs (
      .clk           (clk),
      .reset         (reset),
      .apb           (apb),
      .locked_i      (locked_q),
      .state_i       (state_q),
      .timeout_cnt_i (tcnt_q),
      .pair_count_i  (pair_cnt_q),
      .enable_o      (enable),
      .swap_o        (swap),
      .resync_o      (resync),
      .clr_stats_o   (clr_stats),
      .timeout_o     (timeout)
   );

   assign clean    = remove_pilot(mpx_in, pilot_ref);
   assign gap_next = (gap_q == 32'hFFFF_FFFF) ? gap_q : gap_q + 32'd1;
   // gap_next is the number of cycles elapsed since the R sample once this edge passes.
   assign gap_hit  = (timeout != 32'd0) && (gap_next >= timeout);

   always_comb begin
      state_d     = state_q;
      locked_d    = locked_q;
      gap_d       = gap_q;
      take_first  = 1'b0;
      pair_done   = 1'b0;
      timeout_evt = 1'b0;
      if (!enable) begin
         state_d  = ST_IDLE;
         locked_d = 1'b0;
         gap_d    = '0;
      end else if (resync) begin
         state_d  = ST_WAIT_R;
         locked_d = 1'b0;
         gap_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_WAIT_R;
            ST_WAIT_R: begin
               if (mpx_valid) begin
                  take_first = 1'b1;
                  gap_d      = '0;
                  state_d    = ST_WAIT_L;
               end
            end
            ST_WAIT_L: begin
               if (mpx_valid) begin
                  pair_done = 1'b1;
                  locked_d  = 1'b1;
                  gap_d     = '0;
                  state_d   = ST_WAIT_R;
               end else if (gap_hit) begin
                  timeout_evt = 1'b1;
                  locked_d    = 1'b0;
                  gap_d       = '0;
                  state_d     = ST_WAIT_R;
               end else begin
                  gap_d = gap_next;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      first_d    = first_q;
      out_l_d    = out_l_q;
      out_r_d    = out_r_q;
      out_vld_d  = pair_done;
      pair_cnt_d = pair_cnt_q;
      tcnt_d     = tcnt_q;
      if (take_first) begin
         first_d = clean;
      end
      if (pair_done) begin
         out_l_d = swap ? first_q : clean;
         out_r_d = swap ? clean   : first_q;
      end
      if (clr_stats) begin
         pair_cnt_d = '0;
         tcnt_d     = '0;
      end else begin
         if (pair_done) begin
            pair_cnt_d = pair_cnt_q + 32'd1;
         end
         if (timeout_evt && (tcnt_q != TCNT_MAX)) begin
            tcnt_d = tcnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         first_q    <= '0;
         gap_q      <= '0;
         locked_q   <= 1'b0;
         tcnt_q     <= '0;
         pair_cnt_q <= '0;
         out_l_q    <= '0;
         out_r_q    <= '0;
         out_vld_q  <= 1'b0;
      end else begin
         first_q    <= first_d;
         gap_q      <= gap_d;
         locked_q   <= locked_d;
         tcnt_q     <= tcnt_d;
         pair_cnt_q <= pair_cnt_d;
         out_l_q    <= out_l_d;
         out_r_q    <= out_r_d;
         out_vld_q  <= out_vld_d;
      end
   end

   assign out_l     = out_l_q;
   assign out_r     = out_r_q;
   assign out_valid = out_vld_q;

endmodule

// File: tb/tb_stereo_demux.sv
// Directed bench for stereo_demux: a queue-based pairing model checked every cycle,
// plus hand-computed register/output expectations at the interesting points.
module tb_stereo_demux;

   logic               clk   = 1'b0;
   logic               reset = 1'b0;
   logic [15:0]        mpx_in;
   logic               mpx_valid;
   logic signed [15:0] pilot_ref;
   logic [15:0]        out_l;
   logic [15:0]        out_r;
   logic               out_valid;

   stereo_demux_if apb_if ();

   stereo_demux dut (
      .clk       (clk),
      .reset     (reset),
      .apb       (apb_if),
      .mpx_in    (mpx_in),
      .mpx_valid (mpx_valid),
      .pilot_ref (pilot_ref),
      .out_l     (out_l),
      .out_r     (out_r),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit done     = 1'b0;

   // Model state, in terms of the behaviour rather than the RTL encoding.
   bit          m_en     = 1'b0;
   bit          m_swap   = 1'b0;
   logic [31:0] m_tmo    = 32'd1024;
   bit          m_run    = 1'b0;
   logic [15:0] pend[$];
   int unsigned m_since  = 0;
   logic [31:0] m_pairs  = '0;
   logic [7:0]  m_tcnt   = '0;
   bit          m_locked = 1'b0;
   bit          exp_valid = 1'b0;
   logic [15:0] exp_l    = '0;
   logic [15:0] exp_r    = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      logic [1:0]  st;
      st      = !m_run ? 2'd0 : ((pend.size() == 1) ? 2'd2 : 2'd1);
      s       = '0;
      s[0]    = m_locked;
      s[2:1]  = st;
      s[15:8] = m_tcnt;
      return s;
   endfunction

   task automatic model_reset();
      m_en = 0; m_swap = 0; m_tmo = 32'd1024; m_run = 0; pend.delete();
      m_since = 0; m_pairs = '0; m_tcnt = '0; m_locked = 0;
      exp_valid = 0; exp_l = '0; exp_r = '0;
   endtask

   task automatic model_step();
      logic [15:0] c;
      bit          wr, wr_ctrl, rs, clr;
      wr      = apb_if.psel && apb_if.penable && apb_if.pwrite;
      wr_ctrl = wr && (apb_if.paddr[3:0] == 4'h0);
      rs      = wr_ctrl && apb_if.pwdata[2];
      clr     = wr_ctrl && apb_if.pwdata[3];
      c       = 16'(int'(mpx_in) - int'(pilot_ref) * 256);
      exp_valid = 1'b0;
      if (!m_en) begin
         m_run = 0; pend.delete(); m_locked = 0;
      end else if (rs) begin
         m_run = 1; pend.delete(); m_locked = 0;
      end else if (!m_run) begin
         m_run = 1;
      end else if (mpx_valid) begin
         pend.push_back(c);
         m_since = 0;
         if (pend.size() == 2) begin
            exp_valid = 1'b1;
            exp_l     = m_swap ? pend[0] : pend[1];
            exp_r     = m_swap ? pend[1] : pend[0];
            m_pairs   = m_pairs + 32'd1;
            m_locked  = 1;
            pend.delete();
         end
      end else if (pend.size() == 1) begin
         m_since++;
         if (m_tmo != 0 && m_since >= m_tmo) begin
            pend.delete();
            m_locked = 0;
            if (m_tcnt != 8'd255) m_tcnt = m_tcnt + 8'd1;
         end
      end
      if (clr) begin
         m_pairs = '0;
         m_tcnt  = '0;
      end
      if (wr_ctrl) begin
         m_en   = apb_if.pwdata[0];
         m_swap = apb_if.pwdata[1];
      end
      if (wr && apb_if.paddr[3:0] == 4'h4) m_tmo = apb_if.pwdata;
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) model_reset();
         else        model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (reset && !done) begin
            chk("cyc out_valid", 32'(out_valid), 32'(exp_valid));
            chk("cyc out_l", 32'(out_l), 32'(exp_l));
            chk("cyc out_r", 32'(out_r), 32'(exp_r));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] s, input logic [15:0] p);
      mpx_in = s; pilot_ref = p; mpx_valid = 1'b1;
      tick();
      mpx_valid = 1'b0;
   endtask

   task automatic apb_write_s(input logic [31:0] a, input logic [31:0] d,
                              input bit with_sample, input logic [15:0] s);
      apb_if.psel = 1; apb_if.penable = 0; apb_if.pwrite = 1;
      apb_if.paddr = a; apb_if.pwdata = d;
      tick();
      apb_if.penable = 1;
      if (with_sample) begin
         mpx_in = s; pilot_ref = 16'h0; mpx_valid = 1'b1;
      end
      tick();
      apb_if.psel = 0; apb_if.penable = 0; apb_if.pwrite = 0;
      mpx_valid = 1'b0;
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      apb_write_s(a, d, 1'b0, 16'h0);
   endtask

   task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
      apb_if.paddr = a;
      #1;
      chk(name, apb_if.prdata, exp);
   endtask

   initial begin
      mpx_in = '0; mpx_valid = 0; pilot_ref = '0;
      apb_if.psel = 0; apb_if.penable = 0; apb_if.pwrite = 0;
      apb_if.paddr = '0; apb_if.pwdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst out_l", 32'(out_l), 32'h0);
      chk("rst out_r", 32'(out_r), 32'h0);
      chk("rst out_valid", 32'(out_valid), 32'h0);
      chk_reg("rst CTRL", 32'h0, 32'h0);
      chk_reg("rst TIMEOUT", 32'h4, 32'h400);
      chk_reg("rst PAIR_COUNT", 32'h8, 32'h0);
      tick();
      chk_reg("rst STATUS", 32'hC, 32'h0);
      chk_reg("unmapped read", 32'h10, 32'h0);

      // Strobe in the release cycle is ignored while disabled.
      reset = 1'b1; mpx_in = 16'h9999; mpx_valid = 1'b1;
      tick();
      mpx_valid = 1'b0;
      tick();
      chk_reg("release STATUS", 32'hC, 32'h0);

      apb_write(32'h0, 32'h1);
      tick();
      chk_reg("enable STATUS wait_r", 32'hC, 32'h2);
      send(16'h1234, 16'h0);
      chk_reg("STATUS wait_l", 32'hC, 32'h4);
      send(16'h5678, 16'h0);
      chk("pair1 out_valid", 32'(out_valid), 32'h1);
      chk("pair1 out_r", 32'(out_r), 32'h1234);
      chk("pair1 out_l", 32'(out_l), 32'h5678);
      tick();
      chk("pair1 pulse end", 32'(out_valid), 32'h0);
      chk_reg("pair1 PAIR_COUNT", 32'h8, 32'h1);
      chk_reg("pair1 STATUS", 32'hC, 32'h3);

      send(16'h0334, 16'h0003);
      send(16'h0001, 16'h0000);
      chk("pilot3 out_r", 32'(out_r), 32'h0034);
      chk("pilot3 out_l", 32'(out_l), 32'h0001);
      send(16'h0010, 16'hFFFE);
      send(16'hFF00, 16'h0001);
      chk("negpilot out_r", 32'(out_r), 32'h0210);
      chk("negpilot out_l", 32'(out_l), 32'hFE00);

      apb_write(32'h4, 32'd10);
      send(16'h1111, 16'h0);
      repeat (9) tick();
      chk_reg("gap 9 STATUS", 32'hC, 32'h5);
      tick();
      chk_reg("timeout STATUS", 32'hC, 32'h102);
      chk_reg("timeout PAIR_COUNT", 32'h8, 32'h3);
      repeat (10) tick();
      chk_reg("timeout model STATUS", 32'hC, exp_status());

      send(16'h2222, 16'h0);
      apb_write_s(32'h0, 32'h5, 1'b1, 16'h3333);
      chk_reg("resync STATUS", 32'hC, 32'h102);
      chk_reg("resync self-clear", 32'h0, 32'h1);
      send(16'h4444, 16'h0);
      send(16'h5555, 16'h0);
      chk("resync out_r", 32'(out_r), 32'h4444);
      chk("resync out_l", 32'(out_l), 32'h5555);

      apb_write(32'h4, 32'h0);
      send(16'h0101, 16'h0);
      repeat (30) tick();
      chk_reg("no-timeout STATUS", 32'hC, 32'h105);
      send(16'h0202, 16'h0);
      chk("no-timeout out_l", 32'(out_l), 32'h0202);
      chk_reg("PAIR_COUNT 5", 32'h8, 32'h5);

      apb_write(32'h0, 32'h3);
      send(16'hAAAA, 16'h0);
      send(16'hBBBB, 16'h0);
      chk("swap out_l", 32'(out_l), 32'hAAAA);
      chk("swap out_r", 32'(out_r), 32'hBBBB);

      send(16'h1357, 16'h0);
      apb_write(32'h0, 32'h0);
      tick();
      chk_reg("disable STATUS", 32'hC, 32'h100);
      chk("disable hold out_l", 32'(out_l), 32'hAAAA);
      chk("disable hold out_r", 32'(out_r), 32'hBBBB);
      apb_write(32'h0, 32'h1);
      tick();
      send(16'h0A0A, 16'h0);
      send(16'h0B0B, 16'h0);
      chk("reenable out_r", 32'(out_r), 32'h0A0A);
      chk("reenable out_l", 32'(out_l), 32'h0B0B);

      apb_write(32'h0, 32'h9);
      chk_reg("clr PAIR_COUNT", 32'h8, 32'h0);
      chk_reg("clr STATUS", 32'hC, 32'h3);
      chk_reg("clr self-clear", 32'h0, 32'h1);

      apb_write(32'h4, 32'd2);
      for (int i = 0; i < 260; i++) begin
         send(16'(i), 16'h0);
         tick();
         tick();
      end
      chk_reg("tcnt saturate STATUS", 32'hC, 32'hFF02);
      chk_reg("tcnt model STATUS", 32'hC, exp_status());

      force dut.pair_cnt_q = 32'hFFFF_FFFF;
      m_pairs = 32'hFFFF_FFFF;
      tick();
      release dut.pair_cnt_q;
      tick();
      chk_reg("forced PAIR_COUNT", 32'h8, 32'hFFFF_FFFF);
      send(16'h0C0C, 16'h0);
      send(16'h0D0D, 16'h0);
      chk_reg("wrap PAIR_COUNT", 32'h8, 32'h0);
      chk_reg("wrap STATUS", 32'hC, 32'hFF03);

      send(16'h0E0E, 16'h0);
      #3;
      reset = 1'b0;
      #1;
      chk("async rst out_l", 32'(out_l), 32'h0);
      chk("async rst out_r", 32'(out_r), 32'h0);
      chk("async rst out_valid", 32'(out_valid), 32'h0);
      chk_reg("async rst CTRL", 32'h0, 32'h0);
      chk_reg("async rst TIMEOUT", 32'h4, 32'h400);
      tick();
      chk_reg("async rst PAIR_COUNT", 32'h8, 32'h0);
      chk_reg("async rst STATUS", 32'hC, 32'h0);

      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stereo_demux.md
STEREO_DEMUX -- requirements
Module: stereo_demux

Interface
REQ-001 SHALL have parameter TIMEOUT_DEFAULT, default 32'd1024: reset value of the gap-limit register, in clk cycles.
REQ-002 SHALL have port clk, input, 1: the single clock; all state SHALL be on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have APB ports penable/psel/pwrite (in, 1), paddr (in, 32), pwdata (in, 32) and prdata (out, 32).
REQ-005 SHALL have port mpx_in, input, 16: the time-multiplexed composite sample.
REQ-006 SHALL have port mpx_valid, input, 1: one-cycle strobe qualifying mpx_in.
REQ-007 SHALL have port pilot_ref, input, signed 16: the pilot estimate aligned with mpx_in.
REQ-008 SHALL have ports out_l and out_r, output, 16 each: the recovered channels.
REQ-009 SHALL have port out_valid, output, 1: one-cycle strobe qualifying out_l and out_r.

Function
REQ-010 SHALL compute clean = mpx_in - 256*pilot_ref modulo 2^16, the exact inverse of the encoder sum when pilot_ref matches.
REQ-011 SHALL implement states IDLE, WAIT_R and WAIT_L.
REQ-012 In IDLE (CTRL.enable=0), SHALL ignore mpx_valid and SHALL go to WAIT_R when enable=1.
REQ-013 On mpx_valid in WAIT_R, SHALL store clean as R and go to WAIT_L.
REQ-014 On mpx_valid in WAIT_L, SHALL store clean as L and go to WAIT_R.
REQ-015 On the L acceptance, SHALL update out_l/out_r and pulse out_valid on the next cycle, so latency is 1 clk after the L strobe.
REQ-016 With CTRL.swap=1, SHALL exchange the first and second samples of the pair (first -> out_l).
REQ-017 SHALL hold out_l/out_r between out_valid pulses.
REQ-018 SHALL count clk cycles since the last accepted sample while in WAIT_L.
REQ-019 When that gap count reaches TIMEOUT (non-zero), SHALL discard the partial pair, return to WAIT_R, clear the locked status and increment timeout_cnt, saturating at 255.
REQ-020 TIMEOUT=0 SHALL disable gap detection.
REQ-021 SHALL set locked on the first completed pair and clear it on timeout, resync or disable.
REQ-022 Writing CTRL.resync=1 SHALL force WAIT_R on the next cycle and discard any partial pair; the bit SHALL self-clear and read 0.
REQ-023 If resync and mpx_valid occur in the same cycle, resync SHALL win and the sample SHALL be dropped.
REQ-024 Clearing enable mid-pair SHALL return the block to IDLE, discard the partial pair and leave outputs held.
REQ-025 pair_count SHALL be 32-bit, increment per out_valid and wrap from 0xFFFFFFFF to 0.
REQ-026 pair_count and timeout_cnt SHALL clear when CTRL.clr_stats=1 is written, which SHALL also self-clear.
REQ-027 The APB interface SHALL be zero-wait: a write takes effect on psel&penable&pwrite, and prdata SHALL be combinational from paddr[3:0].
REQ-028 The register map SHALL be:
- 0x0 CTRL: [0] enable, [1] swap, [2] resync, [3] clr_stats.
- 0x4 TIMEOUT: 32-bit.
- 0x8 PAIR_COUNT: read-only.
- 0xC STATUS: [0] locked, [2:1] state, [15:8] timeout_cnt.
- Unmapped addresses read 0.

Reset
REQ-029 Asserting reset SHALL set all of the following: state IDLE, CTRL 0, TIMEOUT=TIMEOUT_DEFAULT, out_l/out_r 0, out_valid 0, counters 0, locked 0.
REQ-030 Deassertion SHALL take effect on the first clk edge after release, and an mpx_valid in that cycle SHALL be ignored because enable=0.

Structure
REQ-031 The state enum, register offsets and CTRL bit positions SHALL live in shared package mpx_pkg, reused by the encoder register block.
REQ-032 Register decode SHALL be sub-module demux_regs; the datapath and FSM SHALL stay in stereo_demux.

Verification
REQ-033 Reset then enable, pilot_ref=0, samples 0x1234 then 0x5678 -> out_r=0x1234, out_l=0x5678, one out_valid pulse, PAIR_COUNT=1.
REQ-034 pilot_ref=0x0003, mpx_in=0x0334 -> stored sample 0x0034.
REQ-035 TIMEOUT=10, one sample then silence -> STATUS.timeout_cnt=1, locked=0, state WAIT_R, no out_valid.
REQ-036 Resync write coincident with mpx_valid -> sample dropped; the next two samples form the pair.
REQ-037 swap=1, samples 0xAAAA then 0xBBBB -> out_l=0xAAAA, out_r=0xBBBB.
REQ-038 Force pair_count=0xFFFFFFFF, complete one pair -> PAIR_COUNT=0; reset asserted mid-pair -> all outputs and registers at their reset values asynchronously.
